d_reg_univ_shift_seq: RTL

- Parametrised WIDTH-bit register with synchronous active-high reset, clock enable and eight operating modes: hold, load, shift left/right, rotate left/right, clear and invert.
- Adds an auto-shift sequencer: one start pulse runs N consecutive shift/rotate operations, with busy/done status.
- Used as the general-purpose enabled storage/serialiser element in datapaths, replacing single-bit enabled flip-flops.

---
 rtl/d_reg_univ_shift_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/d_reg_univ_shift_seq.sv
// ---------------------------------------------------------------------------
// d_reg_univ_shift_seq
// WIDTH-bit universal register (hold/load/shl/shr/rotl/rotr/clear/invert)
// with an auto-shift sequencer: one start pulse runs count_in consecutive
// shift/rotate operations and reports busy/done.
//
// Ports:
//   clk         rising-edge clock
//   reset_in    synchronous active-high reset
//   en_in       clock enable; freezes all state when low (done_out drops)
//   mode_in     operation select (see mode_e)
//   d_in        parallel load data
//   ser_lsb_in  bit shifted into bit 0 on shl
//   ser_msb_in  bit shifted into bit WIDTH-1 on shr
//   start_in    request an auto-shift sequence (shift/rotate modes only)
//   count_in    number of shifts in the auto sequence
//   q_out       register contents
//   ser_out     serial output bit, combinational from q_out
//   busy_out    sequence in progress
//   done_out    one-cycle pulse after the last shift of a sequence
// ---------------------------------------------------------------------------
module d_reg_univ_shift_seq #(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic                             clk,
    input  logic                             reset_in,
    input  logic                             en_in,
    input  logic [2:0]                       mode_in,
    input  logic [WIDTH-1:0]                 d_in,
    input  logic                             ser_lsb_in,
    input  logic                             ser_msb_in,
    input  logic                             start_in,
    input  logic [$clog2(WIDTH+1)-1:0]       count_in,
    output logic [WIDTH-1:0]                 q_out,
    output logic                             ser_out,
    output logic                             busy_out,
    output logic                             done_out
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        M_HOLD   = 3'b000,
        M_LOAD   = 3'b001,
        M_SHL    = 3'b010,
        M_SHR    = 3'b011,
        M_ROTL   = 3'b100,
        M_ROTR   = 3'b101,
        M_CLEAR  = 3'b110,
        M_INVERT = 3'b111
    } mode_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    mode_e            mode_q,  mode_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    mode_e            mode_in_e;
    mode_e            eff_mode;

    assign mode_in_e = mode_e'(mode_in);

    // One edge of the selected operation applied to the current value.
    function automatic logic [WIDTH-1:0] apply_mode(
        input mode_e            m,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             sl,
        input logic             sm
    );
        logic [WIDTH-1:0] r;
        r = cur;
        case (m)
            M_HOLD:   r = cur;
            M_LOAD:   r = ld;
            M_SHL:    r = {cur[WIDTH-2:0], sl};
            M_SHR:    r = {sm, cur[WIDTH-1:1]};
            M_ROTL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROTR:   r = {cur[0], cur[WIDTH-1:1]};
            M_CLEAR:  r = RESET_VAL;
            M_INVERT: r = ~cur;
            default:  r = cur;
        endcase
        return r;
    endfunction

    // Only shift/rotate modes may start a sequence.
    function automatic logic is_seq_mode(input mode_e m);
        return (m == M_SHL) || (m == M_SHR) || (m == M_ROTL) || (m == M_ROTR);
    endfunction

    // State register; enable gating lives in the next-state logic.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            mode_q  <= M_HOLD;
            cnt_q   <= '0;
            q_q     <= RESET_VAL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state: hold everything by default, done is a pulse.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (en_in) begin
            case (state_q)
                S_IDLE: begin
                    if (start_in && is_seq_mode(mode_in_e)) begin
                        // Accept edge: latch only, register unchanged.
                        mode_d = mode_in_e;
                        cnt_d  = count_in;
                        if (count_in == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = S_SHIFT;
                            busy_d  = 1'b1;
                        end
                    end else begin
                        q_d = apply_mode(mode_in_e, q_q, d_in, ser_lsb_in, ser_msb_in);
                    end
                end
                S_SHIFT: begin
                    q_d   = apply_mode(mode_q, q_q, d_in, ser_lsb_in, ser_msb_in);
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Serial tap follows the latched mode while a sequence runs.
    assign eff_mode = (state_q == S_SHIFT) ? mode_q : mode_in_e;
    assign ser_out  = ((eff_mode == M_SHL) || (eff_mode == M_ROTL)) ? q_q[WIDTH-1] : q_q[0];

    assign q_out    = q_q;
    assign busy_out = busy_q;
    assign done_out = done_q;

endmodule
